nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle 16-bit adder that walks one nibble per cycle with a carry-select pair.
// Optional NIBBLE_SERIAL_SUB_EN adds a sub port for a - b via inverted B and forced carry-in.
module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        busy
`ifdef NIBBLE_SERIAL_SUB_EN
  ,
  input  logic        sub
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q;
  logic [15:0] a_q, b_q, sum_q;
  logic [15:0] sum_d;
  logic        carry_q, cout_q;
  logic        accept;
  logic [15:0] b_eff;
  logic        cin_eff;
  logic [3:0]  a_nib, b_nib;
  logic [4:0]  res0, res1, res_sel;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Two's-complement subtract: a + ~b + 1; cin has no say when sub is set.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRun;
      StRun:  if (idx_q == 2'd3) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Nibble select and carry-select pair
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    unique case (idx_q)
      2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
      2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
      2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
      2'd3: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
      default: ;
    endcase
    res0    = {1'b0, a_nib} + {1'b0, b_nib};
    res1    = {1'b0, a_nib} + {1'b0, b_nib} + 5'd1;
    res_sel = carry_q ? res1 : res0;
  end

  always_comb begin
    sum_d = sum_q;
    unique case (idx_q)
      2'd0: sum_d[3:0]   = res_sel[3:0];
      2'd1: sum_d[7:4]   = res_sel[3:0];
      2'd2: sum_d[11:8]  = res_sel[3:0];
      2'd3: sum_d[15:12] = res_sel[3:0];
      default: ;
    endcase
  end

  // Datapath registers; result is cleared on accept so unprocessed nibbles read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 16'h0;
      b_q     <= 16'h0;
      sum_q   <= 16'h0;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      sum_q   <= 16'h0;
      idx_q   <= 2'd0;
      carry_q <= cin_eff;
      cout_q  <= 1'b0;
    end else if (state_q == StRun) begin
      sum_q   <= sum_d;
      carry_q <= res_sel[4];
      idx_q   <= idx_q + 2'd1;
      if (idx_q == 2'd3) cout_q <= res_sel[4];
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus a random back-to-back run
// scored against a plain-arithmetic model.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        sub;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
`ifdef NIBBLE_SERIAL_SUB_EN
    ,
    .sub      (sub)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_sum"}, sum, 0);
    check_eq({tag, "_cout"}, cout, 0);
  endtask

  // Accepts one operand pair and checks partial sums and latency; leaves the DUT in DONE.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic s, input string tag);
    logic [16:0] e;
    logic [15:0] m;
    e = model(x, y, c, s);
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = s;
`endif
    check_eq({tag, "_ready_before"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = 16'h0; b = 16'h0; cin = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_in_ready_run"}, in_ready, 0);
    check_eq({tag, "_sum_cleared"}, sum, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      m = 16'((32'd1 << (4 * k)) - 32'd1);
      check_eq({tag, "_no_early_valid"}, out_valid, 0);
      check_eq({tag, "_partial_sum"}, sum, e[15:0] & m);
    end
    tick();
    check_eq({tag, "_out_valid_T4"}, out_valid, 1);
    check_eq({tag, "_sum"}, sum, e[15:0]);
    check_eq({tag, "_cout"}, cout, e[16]);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_released_valid"}, out_valid, 0);
    check_eq({tag, "_released_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [16:0] e;
    logic [16:0] expq[$];
    int got, cyc, last_acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_1234");
    release_out("add_1234");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    release_out("wrap");
    run_op(16'h000F, 16'h0001, 1'b0, 1'b0, "carry_n0n1");
    release_out("carry_n0n1");

    // Hold the result in DONE while a new request is presented.
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, "hold");
    e = model(16'hABCD, 16'h1111, 1'b1, 1'b0);
    in_valid = 1'b1; a = 16'h5555; b = 16'h2222;
    repeat (10) begin
      tick();
      check_eq("hold_sum", sum, e[15:0]);
      check_eq("hold_cout", cout, e[16]);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    check_eq("release_no_accept", busy, 0);
    check_eq("release_in_ready", in_ready, 1);
    in_valid = 1'b0; out_ready = 1'b0;

    // Abort mid-run with reset.
    a = 16'h7777; b = 16'h8888; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort");
    repeat (8) begin
      tick();
      check_eq("abort_no_valid", out_valid, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "after_abort");
    release_out("after_abort");

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
    release_out("sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_noborrow");
    release_out("sub_noborrow");
    sub = 1'b0;
`endif

    // Back-to-back random traffic.
    got = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    while (got < 1000 && cyc < 7000) begin
      if (in_ready) begin
        expq.push_back(model(a, b, cin, 1'b0));
        if (last_acc >= 0) check_eq("b2b_period", cyc - last_acc, 6);
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check_eq("b2b_spurious_valid", out_valid, 0);
        end else begin
          e = expq.pop_front();
          check_eq("b2b_sum", sum, e[15:0]);
          check_eq("b2b_cout", cout, e[16]);
        end
        got++;
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    end
    check_eq("b2b_result_count", got, 1000);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
